// File: rtl/store_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : store_buffer                                                    |
// | Brief    : Speculative store buffer with commit, flush, in-order drain and |
// |            youngest-match store-to-load forwarding.                        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module store_buffer #(
    parameter int DEPTH    = 8,
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     write_valid_i,
    input  logic [ADDR_LEN-1:0]      write_address_i,
    input  logic [DATA_LEN-1:0]      write_data_i,
    output logic                     write_ready_o,
    input  logic                     commit_i,
    input  logic                     flush_i,
    output logic                     mem_we_o,
    output logic [ADDR_LEN-1:0]      mem_address_o,
    output logic [DATA_LEN-1:0]      mem_data_o,
    input  logic                     mem_ready_i,
    input  logic [ADDR_LEN-1:0]      load_address_i,
    output logic                     load_hit_o,
    output logic [DATA_LEN-1:0]      load_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_PTR_W = c_IDX_W + 1;

    if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("store_buffer: DEPTH must be a power of two in 2..64");
    end

    logic [ADDR_LEN-1:0] r_addr [DEPTH];
    logic [DATA_LEN-1:0] r_data [DEPTH];
    logic [c_PTR_W-1:0]  r_head;
    logic [c_PTR_W-1:0]  r_cmt;
    logic [c_PTR_W-1:0]  r_tail;

    logic [c_PTR_W-1:0]  w_count;
    logic                w_full;
    logic                w_enq;
    logic                w_commit;
    logic                w_pop;
    logic [c_PTR_W-1:0]  w_cmt_next;
    logic [c_PTR_W-1:0]  w_scan_ptr;
    logic                w_hit;
    logic [DATA_LEN-1:0] w_ldata;

    assign w_count  = r_tail - r_head;
    assign w_full   = (w_count == c_PTR_W'(DEPTH));
    assign w_enq    = write_valid_i && !w_full && !flush_i;
    assign w_commit = commit_i && (r_cmt != r_tail);
    assign w_pop    = (r_head != r_cmt) && mem_ready_i;

    // Commit lands before flush so a same-cycle commit keeps its entry.
    assign w_cmt_next = r_cmt + {{(c_PTR_W-1){1'b0}}, w_commit};

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_head <= '0;
            r_cmt  <= '0;
            r_tail <= '0;
        end else begin
            r_head <= r_head + {{(c_PTR_W-1){1'b0}}, w_pop};
            r_cmt  <= w_cmt_next;
            if (flush_i) begin
                r_tail <= w_cmt_next;
            end else begin
                r_tail <= r_tail + {{(c_PTR_W-1){1'b0}}, w_enq};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_addr[r_tail[c_IDX_W-1:0]] <= write_address_i;
            r_data[r_tail[c_IDX_W-1:0]] <= write_data_i;
        end
    end

    // Scan oldest to youngest so the last match (nearest tail) wins.
    always_comb begin
        w_hit      = 1'b0;
        w_ldata    = '0;
        w_scan_ptr = r_head;
        for (int k = 0; k < DEPTH; k++) begin
            w_scan_ptr = r_head + c_PTR_W'(k);
            if ((c_PTR_W'(k) < w_count) &&
                (r_addr[w_scan_ptr[c_IDX_W-1:0]] == load_address_i)) begin
                w_hit   = 1'b1;
                w_ldata = r_data[w_scan_ptr[c_IDX_W-1:0]];
            end
        end
    end

    assign write_ready_o = !w_full;
    assign full_o        = w_full;
    assign empty_o       = (w_count == '0);
    assign count_o       = w_count;
    assign mem_we_o      = (r_head != r_cmt);
    assign mem_address_o = r_addr[r_head[c_IDX_W-1:0]];
    assign mem_data_o    = r_data[r_head[c_IDX_W-1:0]];
    assign load_hit_o    = w_hit;
    assign load_data_o   = w_ldata;

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_store_buffer                                                 |
// | Brief    : Directed, self-checking bench for store_buffer with a queue     |
// |            model compared every cycle plus literal expectations.           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_store_buffer;

    localparam int DEPTH = 8;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          write_valid_i;
    logic [AW-1:0] write_address_i;
    logic [DW-1:0] write_data_i;
    logic          write_ready_o;
    logic          commit_i;
    logic          flush_i;
    logic          mem_we_o;
    logic [AW-1:0] mem_address_o;
    logic [DW-1:0] mem_data_o;
    logic          mem_ready_i;
    logic [AW-1:0] load_address_i;
    logic          load_hit_o;
    logic [DW-1:0] load_data_o;
    logic [3:0]    count_o;
    logic          full_o;
    logic          empty_o;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t q[$];
    int   ncmt = 0;

    store_buffer #(.DEPTH(DEPTH), .ADDR_LEN(AW), .DATA_LEN(DW)) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .write_valid_i   (write_valid_i),
        .write_address_i (write_address_i),
        .write_data_i    (write_data_i),
        .write_ready_o   (write_ready_o),
        .commit_i        (commit_i),
        .flush_i         (flush_i),
        .mem_we_o        (mem_we_o),
        .mem_address_o   (mem_address_o),
        .mem_data_o      (mem_data_o),
        .mem_ready_i     (mem_ready_i),
        .load_address_i  (load_address_i),
        .load_hit_o      (load_hit_o),
        .load_data_o     (load_data_o),
        .count_o         (count_o),
        .full_o          (full_o),
        .empty_o         (empty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: committed entries are the first ncmt elements of q.
    always @(negedge reset_i) begin
        q.delete();
        ncmt = 0;
    end

    always @(posedge clk_i) begin
        if (reset_i) begin
            automatic bit full = (q.size() == DEPTH);
            automatic bit cm   = commit_i && (ncmt < q.size());
            automatic bit pop  = (ncmt > 0) && mem_ready_i;
            automatic bit enq  = write_valid_i && !full && !flush_i;
            if (pop) begin
                void'(q.pop_front());
                ncmt--;
            end
            if (cm) ncmt++;
            if (flush_i) begin
                while (q.size() > ncmt) void'(q.pop_back());
            end
            if (enq) q.push_back('{a: write_address_i, d: write_data_i});
        end
    end

    always @(negedge clk_i) begin
        automatic logic          e_hit = 1'b0;
        automatic logic [DW-1:0] e_ld  = '0;
        foreach (q[i]) begin
            if (q[i].a == load_address_i) begin
                e_hit = 1'b1;
                e_ld  = q[i].d;
            end
        end
        check("cmp_count", 64'(count_o), 64'(q.size()));
        check("cmp_full", 64'(full_o), 64'(q.size() == DEPTH));
        check("cmp_empty", 64'(empty_o), 64'(q.size() == 0));
        check("cmp_ready", 64'(write_ready_o), 64'(q.size() != DEPTH));
        check("cmp_mem_we", 64'(mem_we_o), 64'(ncmt > 0));
        if (ncmt > 0) begin
            check("cmp_mem_addr", 64'(mem_address_o), 64'(q[0].a));
            check("cmp_mem_data", 64'(mem_data_o), 64'(q[0].d));
        end
        check("cmp_load_hit", 64'(load_hit_o), 64'(e_hit));
        check("cmp_load_data", 64'(load_data_o), 64'(e_ld));
    end

    task automatic drive(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic cm, input logic fl);
        write_valid_i   = wv;
        write_address_i = wa;
        write_data_i    = wd;
        commit_i        = cm;
        flush_i         = fl;
        @(posedge clk_i);
        #1;
        write_valid_i = 1'b0;
        commit_i      = 1'b0;
        flush_i       = 1'b0;
    endtask

    initial begin
        reset_i         = 1'b0;
        write_valid_i   = 1'b0;
        write_address_i = '0;
        write_data_i    = '0;
        commit_i        = 1'b0;
        flush_i         = 1'b0;
        mem_ready_i     = 1'b1;
        load_address_i  = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_empty", 64'(empty_o), 64'd1);
        check("rst_full", 64'(full_o), 64'd0);
        check("rst_ready", 64'(write_ready_o), 64'd1);
        check("rst_mem_we", 64'(mem_we_o), 64'd0);
        check("rst_load_hit", 64'(load_hit_o), 64'd0);
        reset_i = 1'b1;

        // Basic write, commit, drain
        drive(1, 32'h100, 32'h11, 0, 0);
        drive(0, 0, 0, 1, 0);
        check("drain_we", 64'(mem_we_o), 64'd1);
        check("drain_addr", 64'(mem_address_o), 64'h100);
        check("drain_data", 64'(mem_data_o), 64'h11);
        drive(0, 0, 0, 0, 0);
        check("drain_empty", 64'(empty_o), 64'd1);

        // Fill to full; 9th write dropped
        for (int i = 0; i < DEPTH; i++) drive(1, 32'h1000 + 32'(i * 4), 32'(i), 0, 0);
        check("fill_full", 64'(full_o), 64'd1);
        check("fill_ready", 64'(write_ready_o), 64'd0);
        drive(1, 32'h9000, 32'hDEAD, 0, 0);
        check("fill_count", 64'(count_o), 64'd8);
        load_address_i = 32'h9000;
        #1;
        check("fill_drop_hit", 64'(load_hit_o), 64'd0);
        load_address_i = 32'h101C;
        #1;
        check("fill_last_hit", 64'(load_hit_o), 64'd1);
        check("fill_last_data", 64'(load_data_o), 64'd7);
        drive(0, 0, 0, 0, 1);
        check("fill_flush_count", 64'(count_o), 64'd0);

        // Youngest forwarding, commit then flush
        mem_ready_i = 1'b0;
        drive(1, 32'h200, 32'h1, 0, 0);
        drive(1, 32'h200, 32'h2, 0, 0);
        load_address_i = 32'h200;
        #1;
        check("fwd_young_data", 64'(load_data_o), 64'h2);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1);
        check("flush_count", 64'(count_o), 64'd1);
        check("flush_hit", 64'(load_hit_o), 64'd1);
        check("flush_data", 64'(load_data_o), 64'h1);
        mem_ready_i = 1'b1;
        drive(0, 0, 0, 0, 0);

        // Backpressure hold
        mem_ready_i = 1'b0;
        drive(1, 32'h300, 32'h33, 0, 0);
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0);
            check("hold_we", 64'(mem_we_o), 64'd1);
            check("hold_addr", 64'(mem_address_o), 64'h300);
            check("hold_data", 64'(mem_data_o), 64'h33);
        end
        mem_ready_i = 1'b1;
        drive(0, 0, 0, 0, 0);
        check("hold_pop_empty", 64'(empty_o), 64'd1);

        // Same-cycle commit+flush, write+flush
        mem_ready_i = 1'b0;
        drive(1, 32'h400, 32'h4, 0, 0);
        drive(1, 32'h404, 32'h5, 0, 0);
        drive(0, 0, 0, 1, 1);
        check("cmflush_count", 64'(count_o), 64'd1);
        drive(1, 32'h500, 32'h6, 0, 1);
        load_address_i = 32'h500;
        #1;
        check("wrflush_count", 64'(count_o), 64'd1);
        check("wrflush_hit", 64'(load_hit_o), 64'd0);
        mem_ready_i = 1'b1;
        drive(0, 0, 0, 0, 0);

        // Wrap-around with concurrent enqueue, commit and drain
        for (int i = 0; i < 40; i++) begin
            mem_ready_i    = (i % 3 != 0);
            load_address_i = 32'h2000 + 32'(((i + 2) % 5) * 4);
            drive(1, 32'h2000 + 32'((i % 5) * 4), 32'(i * 7 + 3), 1, 0);
        end
        mem_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) drive(0, 0, 0, 1, 0);
        check("wrap_empty", 64'(empty_o), 64'd1);

        // Asynchronous reset mid-drain
        mem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) drive(1, 32'h600 + 32'(i * 4), 32'(i + 8), 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0);
        load_address_i = 32'h600;
        #1;
        check("prerst_we", 64'(mem_we_o), 64'd1);
        check("prerst_count", 64'(count_o), 64'd3);
        #1;
        reset_i = 1'b0;
        #1;
        check("async_rst_we", 64'(mem_we_o), 64'd0);
        check("async_rst_count", 64'(count_o), 64'd0);
        check("async_rst_hit", 64'(load_hit_o), 64'd0);
        @(posedge clk_i);
        #1;
        reset_i     = 1'b1;
        mem_ready_i = 1'b1;
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        check("postrst_we", 64'(mem_we_o), 64'd0);
        check("postrst_empty", 64'(empty_o), 64'd1);

        @(negedge clk_i);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
